// File: rtl/ssram_arbiter.sv
// Two-initiator (instruction fetch / load-store) arbiter in front of one ssram port.
// Optional macro SSRAM_ARB_FIXED_PRIO_EN: d-port always wins contention (no round-robin pointer).
module ssram_arbiter #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] IDLE_DATA  = 32'hbaadf00d
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  clk_en_i,

    output logic                  i_treqready_o,
    input  logic                  i_treqvalid_i,
    input  logic                  i_treqdvalid_i,
    input  logic [ADDR_WIDTH-1:0] i_treqaddr_i,
    input  logic [DATA_WIDTH-1:0] i_treqdata_i,
    input  logic                  i_trspready_i,
    output logic                  i_trspvalid_o,
    output logic [DATA_WIDTH-1:0] i_trspdata_o,

    output logic                  d_treqready_o,
    input  logic                  d_treqvalid_i,
    input  logic                  d_treqdvalid_i,
    input  logic [ADDR_WIDTH-1:0] d_treqaddr_i,
    input  logic [DATA_WIDTH-1:0] d_treqdata_i,
    input  logic                  d_trspready_i,
    output logic                  d_trspvalid_o,
    output logic [DATA_WIDTH-1:0] d_trspdata_o,

    input  logic                  m_treqready_i,
    output logic                  m_treqvalid_o,
    output logic                  m_treqdvalid_o,
    output logic [ADDR_WIDTH-1:0] m_treqaddr_o,
    output logic [DATA_WIDTH-1:0] m_treqdata_o,
    output logic                  m_trspready_o,
    input  logic                  m_trspvalid_i,
    input  logic [DATA_WIDTH-1:0] m_trspdata_i
);

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    logic                  inflight_q, inflight_d;
    logic                  owner_q, owner_d;
    logic                  i_buf_vld_q, i_buf_vld_d;
    logic [DATA_WIDTH-1:0] i_buf_data_q, i_buf_data_d;
    logic                  d_buf_vld_q, d_buf_vld_d;
    logic [DATA_WIDTH-1:0] d_buf_data_q, d_buf_data_d;

    logic i_rd_busy, d_rd_busy;
    logic i_elig, d_elig;
    logic grant_i, grant_d;
    logic accept;

    // A port may have only one read outstanding: either buffered or still at the memory.
    assign i_rd_busy = i_buf_vld_q | (inflight_q & (owner_q == PORT_I));
    assign d_rd_busy = d_buf_vld_q | (inflight_q & (owner_q == PORT_D));
    assign i_elig    = i_treqvalid_i & (i_treqdvalid_i | ~i_rd_busy);
    assign d_elig    = d_treqvalid_i & (d_treqdvalid_i | ~d_rd_busy);

`ifdef SSRAM_ARB_FIXED_PRIO_EN
    assign grant_d = d_elig;
    assign grant_i = i_elig & ~d_elig;
`else
    logic ptr_q, ptr_d;

    assign grant_i = i_elig & (~d_elig | (ptr_q == PORT_I));
    assign grant_d = d_elig & ~grant_i;
`endif

    always_comb begin
        m_treqvalid_o  = grant_i | grant_d;
        m_treqdvalid_o = 1'b0;
        m_treqaddr_o   = '0;
        m_treqdata_o   = '0;
        if (grant_i) begin
            m_treqdvalid_o = i_treqdvalid_i;
            m_treqaddr_o   = i_treqaddr_i;
            m_treqdata_o   = i_treqdata_i;
        end else if (grant_d) begin
            m_treqdvalid_o = d_treqdvalid_i;
            m_treqaddr_o   = d_treqaddr_i;
            m_treqdata_o   = d_treqdata_i;
        end
    end

    assign i_treqready_o = grant_i & m_treqready_i;
    assign d_treqready_o = grant_d & m_treqready_i;
    assign accept        = m_treqvalid_o & m_treqready_i;
    assign m_trspready_o = 1'b1;

    assign i_trspvalid_o = i_buf_vld_q;
    assign i_trspdata_o  = i_buf_data_q;
    assign d_trspvalid_o = d_buf_vld_q;
    assign d_trspdata_o  = d_buf_data_q;

    // Buffer data registers are parked at IDLE_DATA whenever the buffer is empty.
    always_comb begin
        inflight_d   = inflight_q;
        owner_d      = owner_q;
        i_buf_vld_d  = i_buf_vld_q;
        i_buf_data_d = i_buf_data_q;
        d_buf_vld_d  = d_buf_vld_q;
        d_buf_data_d = d_buf_data_q;

        if (i_buf_vld_q && i_trspready_i) begin
            i_buf_vld_d  = 1'b0;
            i_buf_data_d = IDLE_DATA;
        end
        if (d_buf_vld_q && d_trspready_i) begin
            d_buf_vld_d  = 1'b0;
            d_buf_data_d = IDLE_DATA;
        end

        // Responses with nothing in flight are stray and dropped.
        if (m_trspvalid_i && inflight_q) begin
            inflight_d = 1'b0;
            if (owner_q == PORT_I) begin
                i_buf_vld_d  = 1'b1;
                i_buf_data_d = m_trspdata_i;
            end else begin
                d_buf_vld_d  = 1'b1;
                d_buf_data_d = m_trspdata_i;
            end
        end

        if (accept && !m_treqdvalid_o) begin
            inflight_d = 1'b1;
            owner_d    = grant_d ? PORT_D : PORT_I;
        end
    end

`ifndef SSRAM_ARB_FIXED_PRIO_EN
    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = grant_i ? PORT_D : PORT_I;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ptr_q <= PORT_I;
        end else if (clk_en_i) begin
            ptr_q <= ptr_d;
        end
    end
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            inflight_q   <= 1'b0;
            owner_q      <= PORT_I;
            i_buf_vld_q  <= 1'b0;
            i_buf_data_q <= IDLE_DATA;
            d_buf_vld_q  <= 1'b0;
            d_buf_data_q <= IDLE_DATA;
        end else if (clk_en_i) begin
            inflight_q   <= inflight_d;
            owner_q      <= owner_d;
            i_buf_vld_q  <= i_buf_vld_d;
            i_buf_data_q <= i_buf_data_d;
            d_buf_vld_q  <= d_buf_vld_d;
            d_buf_data_q <= d_buf_data_d;
        end
    end

endmodule

// File: tb/tb_ssram_arbiter.sv
// Directed bench for ssram_arbiter with a one-cycle-latency memory model behind the m-port.
module tb_ssram_arbiter;

    localparam logic [31:0] IDLE = 32'hbaadf00d;
`ifdef SSRAM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        clk_en_i;
    logic        i_treqready_o, i_treqvalid_i, i_treqdvalid_i;
    logic [31:0] i_treqaddr_i, i_treqdata_i;
    logic        i_trspready_i, i_trspvalid_o;
    logic [31:0] i_trspdata_o;
    logic        d_treqready_o, d_treqvalid_i, d_treqdvalid_i;
    logic [31:0] d_treqaddr_i, d_treqdata_i;
    logic        d_trspready_i, d_trspvalid_o;
    logic [31:0] d_trspdata_o;
    logic        m_treqready_i, m_treqvalid_o, m_treqdvalid_o;
    logic [31:0] m_treqaddr_o, m_treqdata_o;
    logic        m_trspready_o, m_trspvalid_i;
    logic [31:0] m_trspdata_i;

    logic        rsp_vld = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        stray_vld;
    logic [31:0] wr_addr = '0, wr_data = '0;

    int n_checks = 0;
    int n_fail   = 0;

    ssram_arbiter dut (
        .clk_i(clk_i), .reset_i(reset_i), .clk_en_i(clk_en_i),
        .i_treqready_o(i_treqready_o), .i_treqvalid_i(i_treqvalid_i),
        .i_treqdvalid_i(i_treqdvalid_i), .i_treqaddr_i(i_treqaddr_i),
        .i_treqdata_i(i_treqdata_i), .i_trspready_i(i_trspready_i),
        .i_trspvalid_o(i_trspvalid_o), .i_trspdata_o(i_trspdata_o),
        .d_treqready_o(d_treqready_o), .d_treqvalid_i(d_treqvalid_i),
        .d_treqdvalid_i(d_treqdvalid_i), .d_treqaddr_i(d_treqaddr_i),
        .d_treqdata_i(d_treqdata_i), .d_trspready_i(d_trspready_i),
        .d_trspvalid_o(d_trspvalid_o), .d_trspdata_o(d_trspdata_o),
        .m_treqready_i(m_treqready_i), .m_treqvalid_o(m_treqvalid_o),
        .m_treqdvalid_o(m_treqdvalid_o), .m_treqaddr_o(m_treqaddr_o),
        .m_treqdata_o(m_treqdata_o), .m_trspready_o(m_trspready_o),
        .m_trspvalid_i(m_trspvalid_i), .m_trspdata_i(m_trspdata_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h100: return 32'h00000013;
            32'h000: return 32'h11111111;
            32'h040: return 32'h22222222;
            default: return {a[15:0], 16'h5A5A};
        endcase
    endfunction

    // Memory: answers an accepted read on the following cycle, records writes.
    always @(posedge clk_i) begin
        rsp_vld  <= clk_en_i && m_treqvalid_o && m_treqready_i && !m_treqdvalid_o;
        rsp_data <= mem_rd(m_treqaddr_o);
        if (clk_en_i && m_treqvalid_o && m_treqready_i && m_treqdvalid_o) begin
            wr_addr <= m_treqaddr_o;
            wr_data <= m_treqdata_o;
        end
    end

    assign m_trspvalid_i = rsp_vld | stray_vld;
    assign m_trspdata_i  = stray_vld ? 32'hdeadbeef : rsp_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic req_i(input logic v, input logic w, input logic [31:0] a, input logic [31:0] dat);
        i_treqvalid_i = v; i_treqdvalid_i = w; i_treqaddr_i = a; i_treqdata_i = dat;
    endtask

    task automatic req_d(input logic v, input logic w, input logic [31:0] a, input logic [31:0] dat);
        d_treqvalid_i = v; d_treqdvalid_i = w; d_treqaddr_i = a; d_treqdata_i = dat;
    endtask

    initial begin
        logic        got, d_seen;
        logic [31:0] d_rsp;

        reset_i = 1'b1; clk_en_i = 1'b1; stray_vld = 1'b0;
        req_i(0, 0, 0, 0); req_d(0, 0, 0, 0);
        i_trspready_i = 1'b1; d_trspready_i = 1'b1; m_treqready_i = 1'b1;
        settle();
        check("rst_i_vld", i_trspvalid_o, 0);
        check("rst_d_vld", d_trspvalid_o, 0);
        check("rst_i_data", i_trspdata_o, IDLE);
        check("rst_d_data", d_trspdata_o, IDLE);
        check("rst_m_rdy", m_trspready_o, 1);
        check("rst_m_vld", m_treqvalid_o, 0);
        check("rst_m_addr", m_treqaddr_o, 0);
        tick(); tick();
        reset_i = 1'b0;
        tick();

        // Contending reads, pointer at i after reset.
        req_i(1, 0, 32'h0, 0); req_d(1, 0, 32'h40, 0);
        settle();
        check("t2_first_i_rdy", i_treqready_o, !FIXED);
        check("t2_first_d_rdy", d_treqready_o, FIXED);
        check("t2_first_addr", m_treqaddr_o, FIXED ? 32'h40 : 32'h0);
        tick();
        i_treqvalid_i = FIXED; d_treqvalid_i = !FIXED;
        settle();
        check("t2_second_i_rdy", i_treqready_o, FIXED);
        check("t2_second_d_rdy", d_treqready_o, !FIXED);
        check("t2_second_addr", m_treqaddr_o, FIXED ? 32'h0 : 32'h40);
        tick();
        req_i(0, 0, 0, 0); req_d(0, 0, 0, 0);
        check("t2_r1_i_vld", i_trspvalid_o, !FIXED);
        check("t2_r1_d_vld", d_trspvalid_o, FIXED);
        check("t2_r1_i_data", i_trspdata_o, FIXED ? IDLE : 32'h11111111);
        check("t2_r1_d_data", d_trspdata_o, FIXED ? 32'h22222222 : IDLE);
        tick();
        check("t2_r2_i_vld", i_trspvalid_o, FIXED);
        check("t2_r2_d_vld", d_trspvalid_o, !FIXED);
        check("t2_r2_i_data", i_trspdata_o, FIXED ? 32'h11111111 : IDLE);
        check("t2_r2_d_data", d_trspdata_o, FIXED ? IDLE : 32'h22222222);
        tick();
        check("t2_done_i", i_trspvalid_o, 0);
        check("t2_done_d", d_trspvalid_o, 0);

        // d write concurrent with i read.
        req_i(1, 0, 32'h8, 0); req_d(1, 1, 32'h600, 32'h41);
        settle();
        check("t3_first_wr", m_treqdvalid_o, FIXED);
        check("t3_first_i_rdy", i_treqready_o, !FIXED);
        tick();
        i_treqvalid_i = FIXED; d_treqvalid_i = !FIXED;
        settle();
        check("t3_second_wr", m_treqdvalid_o, !FIXED);
        check("t3_second_d_rdy", d_treqready_o, !FIXED);
        tick();
        req_i(0, 0, 0, 0); req_d(0, 0, 0, 0);
        got = i_trspvalid_o; d_seen = d_trspvalid_o;
        for (int k = 0; k < 6 && !got; k++) begin
            tick();
            if (d_trspvalid_o) d_seen = 1'b1;
            if (i_trspvalid_o) got = 1'b1;
        end
        check("t3_i_rsp_seen", got, 1);
        check("t3_i_data", i_trspdata_o, 32'h00085A5A);
        check("t3_no_d_rsp", d_seen, 0);
        check("t3_wr_addr", wr_addr, 32'h600);
        check("t3_wr_data", wr_data, 32'h41);
        tick();

        // Single i read, with memory back-pressure and clock-enable low first.
        req_i(1, 0, 32'h100, 0); m_treqready_i = 1'b0;
        settle();
        check("t1_mvld_no_rdy", m_treqvalid_o, 1);
        check("t1_i_rdy_blocked", i_treqready_o, 0);
        tick();
        m_treqready_i = 1'b1; clk_en_i = 1'b0;
        settle();
        check("t1_i_rdy_noen", i_treqready_o, 1);
        tick(); tick();
        check("t1_no_accept_noen", i_trspvalid_o, 0);
        clk_en_i = 1'b1;
        tick();
        req_i(0, 0, 0, 0);
        settle();
        check("t1_wait_vld", i_trspvalid_o, 0);
        check("t1_m_idle", m_treqvalid_o, 0);
        tick();
        check("t1_i_vld", i_trspvalid_o, 1);
        check("t1_i_data", i_trspdata_o, 32'h00000013);
        check("t1_d_vld", d_trspvalid_o, 0);
        check("t1_d_data", d_trspdata_o, IDLE);
        tick();
        check("t1_i_clr", i_trspvalid_o, 0);
        check("t1_i_idle", i_trspdata_o, IDLE);

        // i response held while i_trspready is low; d keeps being served.
        i_trspready_i = 1'b0;
        req_i(1, 0, 32'h100, 0);
        tick();
        req_i(0, 0, 0, 0);
        tick();
        req_i(1, 0, 32'h104, 0); req_d(1, 0, 32'h40, 0);
        settle();
        check("t4_i_rdy_full", i_treqready_o, 0);
        check("t4_d_rdy", d_treqready_o, 1);
        d_rsp = '0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 0) req_d(0, 0, 0, 0);
            if (d_trspvalid_o) d_rsp = d_trspdata_o;
            check("t4_hold_vld", i_trspvalid_o, 1);
            check("t4_hold_data", i_trspdata_o, 32'h00000013);
            check("t4_hold_rdy", i_treqready_o, 0);
        end
        check("t4_d_rsp", d_rsp, 32'h22222222);
        i_trspready_i = 1'b1;
        settle();
        check("t4_rdy_before_dlv", i_treqready_o, 0);
        tick();
        check("t4_dlv_clr", i_trspvalid_o, 0);
        check("t4_dlv_idle", i_trspdata_o, IDLE);
        check("t4_new_rdy", i_treqready_o, 1);
        tick();
        req_i(0, 0, 0, 0);
        tick();
        check("t4_new_vld", i_trspvalid_o, 1);
        check("t4_new_data", i_trspdata_o, 32'h01045A5A);
        tick();

        // Stray response with nothing in flight.
        stray_vld = 1'b1;
        tick();
        stray_vld = 1'b0;
        check("t5_i_vld", i_trspvalid_o, 0);
        check("t5_d_vld", d_trspvalid_o, 0);
        check("t5_i_data", i_trspdata_o, IDLE);
        check("t5_d_data", d_trspdata_o, IDLE);
        tick();
        check("t5_i_vld2", i_trspvalid_o, 0);
        check("t5_d_vld2", d_trspvalid_o, 0);

        // Asynchronous reset with a buffered i response and a d read in flight.
        i_trspready_i = 1'b0;
        req_i(1, 0, 32'h100, 0);
        tick();
        req_i(0, 0, 0, 0);
        tick();
        check("t6_i_buffered", i_trspvalid_o, 1);
        req_d(1, 0, 32'h40, 0);
        tick();
        req_d(0, 0, 0, 0);
        #2 reset_i = 1'b1;
        #1;
        check("t6_async_i_vld", i_trspvalid_o, 0);
        check("t6_async_i_data", i_trspdata_o, IDLE);
        #1 reset_i = 1'b0;
        i_trspready_i = 1'b1;
        tick();
        check("t6_late_d_vld", d_trspvalid_o, 0);
        check("t6_late_d_data", d_trspdata_o, IDLE);
        tick();
        check("t6_late_d_vld2", d_trspvalid_o, 0);
        req_i(1, 0, 32'h0, 0); req_d(1, 0, 32'h40, 0);
        settle();
        check("t6_ptr_i_rdy", i_treqready_o, !FIXED);
        check("t6_ptr_d_rdy", d_treqready_o, FIXED);
        req_i(0, 0, 0, 0); req_d(0, 0, 0, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
